jacobi_rotation_fifo: RTL and testbench

Result buffer between the rotation CORDIC and the Jacobi main controller. It captures every valid (x, y, z) triple that the rotation CORDIC produces and presents the triples in order to the controller through a valid/ready handshake. The CORDIC pipeline has no backpressure, so the buffer provides these signals to the controller:
- an occupancy count and an almost-full flag, which the controller uses to throttle issue into the rotation CORDIC;
- a sticky overflow flag for lost results.

---
 rtl/jacobi_rotation_fifo.sv | 118 +++++++++++
 tb/tb_jacobi_rotation_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_rotation_fifo.sv
// Result buffer between the rotation CORDIC and the Jacobi controller.
// The CORDIC cannot be stalled, so a push into a full buffer is dropped and recorded in a sticky flag.
package jacobi_pkg;
  parameter int JACOBI_OUTPUT_WORD_WIDTH = 16;
endpackage

module jacobi_rotation_fifo
  import jacobi_pkg::*;
#(
  parameter int WORD_WIDTH  = JACOBI_OUTPUT_WORD_WIDTH,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 2,
  parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] in_dat_x_i,
  input  logic [WORD_WIDTH-1:0] in_dat_y_i,
  input  logic [WORD_WIDTH-1:0] in_dat_z_i,
  input  logic                  in_vld_i,
  input  logic                  flush_i,
  output logic [WORD_WIDTH-1:0] out_dat_x_o,
  output logic [WORD_WIDTH-1:0] out_dat_y_o,
  output logic [WORD_WIDTH-1:0] out_dat_z_o,
  output logic                  out_vld_o,
  input  logic                  out_rdy_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  almost_full_o,
  output logic                  overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [WORD_WIDTH-1:0] x;
    logic [WORD_WIDTH-1:0] y;
    logic [WORD_WIDTH-1:0] z;
  } trip_t;

  trip_t                mem_q [DEPTH];
  trip_t                wr_dat;
  trip_t                head;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 afull_q, afull_d;
  logic                 ovf_q, ovf_d;
  logic                 full, vld, push, pop, drop;

  always_comb begin
    full = (count_q == CNT_WIDTH'(DEPTH));
    vld  = (count_q != '0);
    pop  = vld & out_rdy_i & ~flush_i;
    // A slot freed by a same-cycle pop lets a push into a full buffer through.
    push = in_vld_i & (~full | pop) & ~flush_i;
    drop = in_vld_i & full & ~pop & ~flush_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | drop;
    end

    afull_d = (count_d >= CNT_WIDTH'(AFULL_LEVEL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr_dat = '{x: in_dat_x_i, y: in_dat_y_i, z: in_dat_z_i};

  // Storage carries no reset; the empty-gated output below hides stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat;
  end

  always_comb begin
    head = '0;
    if (vld) head = mem_q[rd_ptr_q];
  end

  assign out_dat_x_o   = head.x;
  assign out_dat_y_o   = head.y;
  assign out_dat_z_o   = head.z;
  assign out_vld_o     = vld;
  assign count_o       = count_q;
  assign almost_full_o = afull_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_jacobi_rotation_fifo.sv
// Bench for jacobi_rotation_fifo: queue-based reference model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_jacobi_rotation_fifo;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_x = '0, in_y = '0, in_z = '0;
  logic          in_vld = 1'b0, flush = 1'b0, out_rdy = 1'b0;
  logic [W-1:0]  out_x, out_y, out_z;
  logic          out_vld, afull, ovf;
  logic [CW-1:0] count;

  int checks = 0;
  int failures = 0;

  jacobi_rotation_fifo #(.WORD_WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_dat_x_i(in_x), .in_dat_y_i(in_y), .in_dat_z_i(in_z),
    .in_vld_i(in_vld), .flush_i(flush),
    .out_dat_x_o(out_x), .out_dat_y_o(out_y), .out_dat_z_o(out_z),
    .out_vld_o(out_vld), .out_rdy_i(out_rdy),
    .count_o(count), .almost_full_o(afull), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of triples plus a sticky drop flag.
  typedef struct packed { logic [W-1:0] x, y, z; } trip_t;
  trip_t m_q[$];
  bit    m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      bit p_pop, p_push;
      p_pop  = (m_q.size() > 0) && out_rdy;
      p_push = in_vld && ((m_q.size() < D) || p_pop);
      if (in_vld && !p_push) m_ovf = 1'b1;
      if (p_pop)  void'(m_q.pop_front());
      if (p_push) m_q.push_back('{x: in_x, y: in_y, z: in_z});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_vld",   32'(out_vld), 32'(m_q.size() != 0));
      chk("m_count", 32'(count),   32'(m_q.size()));
      chk("m_afull", 32'(afull),   32'(m_q.size() >= AF));
      chk("m_ovf",   32'(ovf),     32'(m_ovf));
      if (m_q.size() != 0) begin
        chk("m_x", 32'(out_x), 32'(m_q[0].x));
        chk("m_y", 32'(out_y), 32'(m_q[0].y));
        chk("m_z", 32'(out_z), 32'(m_q[0].z));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input int x, input int y, input int z, input bit r, input bit f);
    in_vld = v; in_x = W'(x); in_y = W'(y); in_z = W'(z); out_rdy = r; flush = f;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cap[$];
    int last_z;

    // Reset state
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_vld",   32'(out_vld), 0);
    chk("rst_afull", 32'(afull), 0);
    chk("rst_ovf",   32'(ovf), 0);
    chk("rst_x",     32'(out_x), 0);
    @(negedge clk); rst = 1'b0;

    // Three pushes with controller stalled
    drive(1, 1, 2, 3, 0, 0); step();
    chk("t1_vld_after_first", 32'(out_vld), 1);
    drive(1, 4, 5, 6, 0, 0); step();
    drive(1, 7, 8, 9, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_count", 32'(count), 3);
    chk("t1_hx", 32'(out_x), 1);
    chk("t1_hy", 32'(out_y), 2);
    chk("t1_hz", 32'(out_z), 3);
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step();
    chk("t1_drained", 32'(count), 0);

    // Streaming with ready held high
    for (int k = 0; k < 20; k++) begin
      drive(1, k, 0, 0, 1, 0); step();
      chk("t2_x", 32'(out_x), 32'(k));
      chk("t2_count", 32'(count), 1);
    end
    drive(0, 0, 0, 0, 1, 0); step();
    chk("t2_empty", 32'(count), 0);
    chk("t2_ovf", 32'(ovf), 0);

    // Fill to almost-full and full
    for (int k = 0; k < 5; k++) begin
      drive(1, k, k + 1, k + 2, 0, 0); step();
    end
    chk("t3_count5", 32'(count), 5);
    chk("t3_afull5", 32'(afull), 0);
    drive(1, 5, 6, 7, 0, 0); step();
    chk("t3_count6", 32'(count), 6);
    chk("t3_afull6", 32'(afull), 1);
    drive(1, 6, 7, 8, 0, 0); step();
    drive(1, 7, 8, 9, 0, 0); step();
    chk("t3_count8", 32'(count), 8);
    chk("t3_ovf0", 32'(ovf), 0);

    // Push and pop together while full
    drive(1, 9, 9, 9, 1, 0);
    chk("t4_head_popped", 32'(out_x), 0);
    step();
    chk("t4_count", 32'(count), 8);
    chk("t4_ovf", 32'(ovf), 0);
    chk("t4_head", 32'(out_x), 1);

    // Push into full with no pop is dropped
    drive(1, 99, 99, 99, 0, 0); step();
    chk("t3_ovf1", 32'(ovf), 1);
    chk("t3_count_stays", 32'(count), 8);

    // Drain and capture order
    drive(0, 0, 0, 0, 1, 0);
    last_z = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_vld) begin
        cap.push_back(int'(out_x));
        last_z = int'(out_z);
      end
      step();
    end
    chk("drain_n", 32'(cap.size()), 8);
    for (int i = 0; i < 7; i++) chk("drain_x", 32'(cap[i]), 32'(i + 1));
    chk("drain_last_x", 32'(cap[7]), 9);
    chk("drain_last_z", 32'(last_z), 9);
    chk("drain_ovf_sticky", 32'(ovf), 1);

    // Flush together with a push
    for (int k = 0; k < 5; k++) begin
      drive(1, 40 + k, 0, 0, 0, 0); step();
    end
    chk("t5_count5", 32'(count), 5);
    drive(1, 77, 77, 77, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_count", 32'(count), 0);
    chk("t5_vld", 32'(out_vld), 0);
    chk("t5_ovf", 32'(ovf), 0);
    chk("t5_afull", 32'(afull), 0);
    step();
    chk("t5_no_entry", 32'(count), 0);

    // Wrap-around with random ready, checked by the model
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 12; k++) begin
        drive(1, 100 * r + k, k, ~k, bit'($urandom_range(0, 1)), 0); step();
      end
      for (int k = 0; k < 40 && count != 0; k++) begin
        drive(0, 0, 0, 0, bit'($urandom_range(0, 1)), 0); step();
      end
      chk("t6_drained", 32'(count), 0);
    end

    // Asynchronous reset mid-stream
    for (int k = 0; k < 4; k++) begin
      drive(1, 200 + k, 1, 2, 0, 0); step();
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_vld",   32'(out_vld), 0);
    chk("ar_afull", 32'(afull), 0);
    chk("ar_ovf",   32'(ovf), 0);
    chk("ar_x",     32'(out_x), 0);
    chk("ar_y",     32'(out_y), 0);
    chk("ar_z",     32'(out_z), 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    step(); step();
    chk("ar_after", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
